// File: rtl/playfield_clear_ctrl.sv
// rtl/playfield_clear_ctrl.sv - line-clear sequencer: compacts non-full rows, zero-fills the top, scores.
// Optional COMBO_SCORE_EN selects tiered combo scoring instead of linear points per line.
module playfield_clear_ctrl #(
  parameter int ROWS     = 20,
  parameter int COLS     = 10,
  parameter int CELL_W   = 4,
  parameter int LINE_PTS = 100,
  localparam int AW = $clog2(ROWS),
  localparam int NW = $clog2(ROWS + 1),
  localparam int DW = COLS * CELL_W
) (
  input  logic          gm_clk,
  input  logic          gm_rst,
  input  logic          start,
  input  logic          score_clr,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] lines_cleared,
  output logic [15:0]   score,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EV, S_FILL, S_DONE} state_t;

  state_t        state, state_d;
  logic [AW-1:0] r, r_d, w, w_d, f, f_d;
  logic [NW-1:0] n, n_d;
  logic          row_full;
  logic [16:0]   inc, sum;

`ifdef COMBO_SCORE_EN
  function automatic logic [16:0] line_inc(input logic [NW-1:0] k);
    logic [16:0] rem_pts;
    case (k[1:0])
      2'd1:    rem_pts = 17'd100;
      2'd2:    rem_pts = 17'd300;
      2'd3:    rem_pts = 17'd500;
      default: rem_pts = 17'd0;
    endcase
    return 17'(k >> 2) * 17'd800 + rem_pts;
  endfunction
`else
  function automatic logic [16:0] line_inc(input logic [NW-1:0] k);
    return 17'(k) * 17'(LINE_PTS);
  endfunction
`endif

  assign inc     = line_inc(n);
  assign sum     = {1'b0, score} + inc;
  assign busy    = (state == S_RD) || (state == S_EV) || (state == S_FILL);
  assign done    = (state == S_DONE);
  assign rd_addr = r;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (rd_data[c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
    end
  end

  always_comb begin
    state_d = state;
    r_d     = r;
    w_d     = w;
    n_d     = n;
    f_d     = f;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          r_d     = AW'(ROWS - 1);
          w_d     = AW'(ROWS - 1);
          n_d     = '0;
          f_d     = '0;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_EV;
      S_EV: begin
        if (row_full) begin
          n_d = n + 1'b1;
        end else begin
          // w only trails r once a full row has been skipped
          if (w != r) begin
            wr_en   = 1'b1;
            wr_addr = w;
            wr_data = rd_data;
          end
          w_d = w - 1'b1;
        end
        if (r == '0) begin
          state_d = (n_d != '0) ? S_FILL : S_DONE;
        end else begin
          r_d     = r - 1'b1;
          state_d = S_RD;
        end
      end
      S_FILL: begin
        wr_en   = 1'b1;
        wr_addr = f;
        f_d     = f + 1'b1;
        if (NW'(f) + 1'b1 == n) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gm_clk or posedge gm_rst) begin
    if (gm_rst) begin
      state <= S_IDLE;
      r     <= '0;
      w     <= '0;
      n     <= '0;
      f     <= '0;
    end else begin
      state <= state_d;
      r     <= r_d;
      w     <= w_d;
      n     <= n_d;
      f     <= f_d;
    end
  end

  // clear beats a coincident end-of-pass increment
  always_ff @(posedge gm_clk or posedge gm_rst) begin
    if (gm_rst) begin
      score         <= '0;
      lines_cleared <= '0;
    end else begin
      if (state == S_DONE) lines_cleared <= n;
      if (score_clr) score <= '0;
      else if (state == S_DONE) score <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

endmodule
